ifmap_bank_buffer: RTL
======================

// Module: ifmap_bank_buffer
// PURPOSE
// - N-bank ifmap line buffer between the decompressor FIFO and the PE NoC. Generalises the two-bank ping-pong scheme.
// - Takes masked byte packets, compacts the valid lanes and packs them into rows of a runtime-configured line/element geometry.
// - Banks fill and drain strictly round-robin. Layer geometry comes from config ports, not from a hard-coded layer enum.
// PARAMETERS
// - NUM_BANKS  2    number of banks, >=2
// - MAX_LINES  35   rows per bank
// - MAX_ELEMS  256  bytes per row
// - IN_ELEMS   8    byte lanes per input packet
// - DATA_W     8    bits per element
// PORTS
// - clk            in   1                      clock, rising edge
// - rst            in   1                      asynchronous, active-high reset
// - start          in   1                      pulse: clear all state, latch cfg_*
// - cfg_lines      in   clog2(MAX_LINES+1)     rows used per bank
// - cfg_elems      in   clog2(MAX_ELEMS+1)     bytes used per row
// - cfg_fills      in   8                      banks to fill per layer (0 = unbounded)
// - in_valid       in   1                      input packet valid
// - in_ready       out  1                      buffer accepts the packet
// - in_mask        in   IN_ELEMS               valid lanes of the packet
// - in_data        in   IN_ELEMS*DATA_W        lane data, lane 0 in the LSBs
// - out_valid      out  1                      bank at rd_ptr is READY
// - out_bank       out  clog2(NUM_BANKS)       rd_ptr
// - out_data       out  MAX_LINES*MAX_ELEMS*DATA_W  contents of bank rd_ptr
// - release_bank   in   1                      NoC finished with bank rd_ptr
// - layer_done     out  1                      cfg_fills banks have completed
// - cfg_err        out  1                      latched cfg is illegal
// BEHAVIOUR
// - Reset / start:
//   - All banks FREE and zeroed; wr_ptr=rd_ptr=0; fill_cnt=0.
//   - Every output is 0.
//   - start is synchronous and takes priority over all other inputs in the same cycle. No packet is accepted that cycle.
// - cfg_err:
//   - Set when cfg_lines==0, cfg_lines>MAX_LINES, cfg_elems<IN_ELEMS or cfg_elems>MAX_ELEMS.
//   - While cfg_err is set, in_ready=0.
// - Bank states: FREE -> FILL -> READY -> FREE.
//   - FREE->FILL: when wr_ptr points at a FREE bank and the layer is not done.
//   - FILL->READY: on the beat that writes byte (cfg_lines*cfg_elems - 1).
//   - READY->FREE: on release_bank. The bank is zeroed in the same edge.
// - in_ready = bank[wr_ptr] in FILL, and !layer_done, and !cfg_err.
// - Accept: handshake is in_valid & in_ready.
//   - Valid lanes are compacted in ascending lane order to positions (line,elem)..(+popcount-1).
//   - At elem==cfg_elems the write wraps to elem 0 of line+1. At most one wrap per beat.
//   - popcount(in_mask)==0 is accepted and changes nothing.
// - Bank-completing beat:
//   - Bytes beyond the bank end are dropped.
//   - wr_ptr advances modulo NUM_BANKS and the line/elem pointers clear.
//   - fill_cnt increments, saturating at cfg_fills.
// - Latency: the completing beat at edge N gives out_valid=1 after edge N.
//   - out_data is combinational from bank rd_ptr and valid only while out_valid.
// - release_bank:
//   - Ignored when out_valid=0.
//   - Otherwise rd_ptr advances modulo NUM_BANKS. out_valid updates next cycle for the new rd_ptr.
// - Simultaneous release and fill of different banks both take effect. A released bank can refill from the next cycle.
// - All banks READY: in_ready=0 (backpressure), no data is lost.
// - layer_done = cfg_fills!=0 && fill_cnt==cfg_fills. It stays set until start or rst.
// - Widths: line and elem pointers are clog2(MAX_LINES) and clog2(MAX_ELEMS+IN_ELEMS) bits, so the wrap compare cannot overflow.
// STRUCTURE
// - Shared package: ifmap packet typedef (mask+data), bank_state_e {FREE,FILL,READY}, default geometry localparams per layer.
// - Sub-module ifmap_bank: one bank's storage, compacting write, pointers and clear. The top level instantiates NUM_BANKS of them.
// - Reuse the existing countones for popcount.
// TESTING
// - cfg 13x13, fills=1; 22 beats of 8 lanes, last beat 1 lane -> out_valid after the 169th byte; bytes in row order; layer_done=1.
// - cfg_elems=27; beat at elem 24 with 8 lanes -> bytes 0-2 at line n elems 24-26, bytes 3-7 at line n+1 elems 0-4.
// - mask 8'b1010_0101 -> lanes 0,2,5,7 stored at elems 0..3; pointer +4.
// - NUM_BANKS=2, no release -> after 2 banks fill, in_ready=0; release_bank -> bank0 cleared, in_ready=1 next cycle, out_bank=1.
// - cfg_lines=0 -> cfg_err=1, in_ready=0; start with a legal cfg -> cfg_err=0.
// - Mid-fill (line 5) apply rst, then separately start -> all outputs 0, next packet lands at line 0 elem 0.

Source files
------------

// File: rtl/ifmap_bank_buffer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifmap_bank_buffer_pkg : shared types, default layer geometry, popcount.
// Revision: 1.0
// ---------------------------------------------------------------------------
package ifmap_bank_buffer_pkg;

    typedef enum logic [1:0] {
        BANK_FREE  = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_READY = 2'd2
    } bank_state_e;

    localparam int PKT_LANES = 8;
    localparam int PKT_DW    = 8;

    typedef struct packed {
        logic [PKT_LANES-1:0]        mask;
        logic [PKT_LANES*PKT_DW-1:0] data;
    } ifmap_pkt_t;

    // Typical layer geometries (rows x bytes per row) used when programming cfg_*.
    localparam int L1_LINES = 35;
    localparam int L1_ELEMS = 256;
    localparam int L2_LINES = 27;
    localparam int L2_ELEMS = 27;
    localparam int L3_LINES = 13;
    localparam int L3_ELEMS = 13;

    function automatic int countones(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + (v[i] ? 1 : 0);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifmap_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifmap_bank : one bank of the ifmap line buffer with compacting lane write.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ifmap_bank
    import ifmap_bank_buffer_pkg::*;
#(
    parameter int MAX_LINES = 35,
    parameter int MAX_ELEMS = 256,
    parameter int IN_ELEMS  = 8,
    parameter int DATA_W    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  clear_i,
    input  logic                                  wr_en_i,
    input  logic [$clog2(MAX_LINES+1)-1:0]        cfg_lines_i,
    input  logic [$clog2(MAX_ELEMS+1)-1:0]        cfg_elems_i,
    input  logic [IN_ELEMS-1:0]                   in_mask_i,
    input  logic [IN_ELEMS*DATA_W-1:0]            in_data_i,
    output logic                                  done_o,
    output logic [MAX_LINES*MAX_ELEMS*DATA_W-1:0] data_o
);

    localparam int LW  = $clog2(MAX_LINES);
    localparam int EW  = $clog2(MAX_ELEMS + IN_ELEMS);
    localparam int EIW = $clog2(MAX_ELEMS);

    logic [DATA_W-1:0] mem_q [MAX_LINES][MAX_ELEMS];
    logic [LW-1:0]     line_q, line_d;
    logic [EW-1:0]     elem_q, elem_d;

    logic [LW-1:0]     lane_line [IN_ELEMS];
    logic [EIW-1:0]    lane_elem [IN_ELEMS];
    logic [IN_ELEMS-1:0] lane_we;

    // Lane k lands at the cursor plus the number of valid lanes below it.
    always_comb begin
        int off;
        int pos;
        int tl;
        int te;
        for (int k = 0; k < IN_ELEMS; k++) begin
            off = countones(32'(in_mask_i) & ((32'd1 << k) - 32'd1));
            pos = int'(elem_q) + off;
            if (pos >= int'(cfg_elems_i)) begin
                tl = int'(line_q) + 1;
                te = pos - int'(cfg_elems_i);
            end else begin
                tl = int'(line_q);
                te = pos;
            end
            lane_we[k]   = wr_en_i && in_mask_i[k] && (tl < int'(cfg_lines_i));
            lane_line[k] = LW'(tl);
            lane_elem[k] = EIW'(te);
        end
    end

    always_comb begin
        int pc;
        int npos;
        pc     = countones(32'(in_mask_i));
        npos   = int'(elem_q) + pc;
        line_d = line_q;
        elem_d = elem_q;
        done_o = 1'b0;
        if (wr_en_i) begin
            if (npos >= int'(cfg_elems_i)) begin
                if (int'(line_q) + 1 >= int'(cfg_lines_i)) begin
                    done_o = 1'b1;
                    line_d = '0;
                    elem_d = '0;
                end else begin
                    line_d = line_q + LW'(1);
                    elem_d = EW'(npos - int'(cfg_elems_i));
                end
            end else begin
                elem_d = EW'(npos);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            elem_q <= '0;
        end else if (clear_i) begin
            line_q <= '0;
            elem_q <= '0;
        end else begin
            line_q <= line_d;
            elem_q <= elem_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < MAX_LINES; l++) begin
                for (int e = 0; e < MAX_ELEMS; e++) begin
                    mem_q[l][e] <= '0;
                end
            end
        end else if (clear_i) begin
            for (int l = 0; l < MAX_LINES; l++) begin
                for (int e = 0; e < MAX_ELEMS; e++) begin
                    mem_q[l][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < IN_ELEMS; k++) begin
                if (lane_we[k]) begin
                    mem_q[lane_line[k]][lane_elem[k]] <= in_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar l = 0; l < MAX_LINES; l++) begin : g_line
        for (genvar e = 0; e < MAX_ELEMS; e++) begin : g_elem
            assign data_o[(l*MAX_ELEMS+e)*DATA_W +: DATA_W] = mem_q[l][e];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifmap_bank_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ifmap_bank_buffer : N-bank round-robin ifmap line buffer (decompressor -> NoC).
// Revision: 1.0
// ---------------------------------------------------------------------------
module ifmap_bank_buffer
    import ifmap_bank_buffer_pkg::*;
#(
    parameter int NUM_BANKS = 2,
    parameter int MAX_LINES = 35,
    parameter int MAX_ELEMS = 256,
    parameter int IN_ELEMS  = 8,
    parameter int DATA_W    = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_i,
    input  logic [$clog2(MAX_LINES+1)-1:0]        cfg_lines_i,
    input  logic [$clog2(MAX_ELEMS+1)-1:0]        cfg_elems_i,
    input  logic [7:0]                            cfg_fills_i,
    input  logic                                  in_valid_i,
    output logic                                  in_ready_o,
    input  logic [IN_ELEMS-1:0]                   in_mask_i,
    input  logic [IN_ELEMS*DATA_W-1:0]            in_data_i,
    output logic                                  out_valid_o,
    output logic [$clog2(NUM_BANKS)-1:0]          out_bank_o,
    output logic [MAX_LINES*MAX_ELEMS*DATA_W-1:0] out_data_o,
    input  logic                                  release_bank_i,
    output logic                                  layer_done_o,
    output logic                                  cfg_err_o
);

    localparam int BW  = $clog2(NUM_BANKS);
    localparam int CLW = $clog2(MAX_LINES + 1);
    localparam int CEW = $clog2(MAX_ELEMS + 1);
    localparam int DW  = MAX_LINES * MAX_ELEMS * DATA_W;

    bank_state_e       state_q [NUM_BANKS];
    logic [BW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [7:0]        fill_cnt_q;
    logic [CLW-1:0]    cfg_lines_q;
    logic [CEW-1:0]    cfg_elems_q;
    logic [7:0]        cfg_fills_q;
    logic              cfg_err_q;

    logic              cfg_bad;
    logic              layer_done;
    logic              accept;
    logic              rel_fire;
    logic              wr_done;
    logic [NUM_BANKS-1:0] bank_done;
    logic [DW-1:0]     bank_data [NUM_BANKS];

    function automatic logic [BW-1:0] next_ptr(input logic [BW-1:0] p);
        return (int'(p) == NUM_BANKS - 1) ? '0 : p + BW'(1);
    endfunction

    assign cfg_bad = (cfg_lines_i == '0) || (int'(cfg_lines_i) > MAX_LINES) ||
                     (int'(cfg_elems_i) < IN_ELEMS) || (int'(cfg_elems_i) > MAX_ELEMS);

    assign layer_done  = (cfg_fills_q != 8'd0) && (fill_cnt_q == cfg_fills_q);
    assign in_ready_o  = (state_q[wr_ptr_q] == BANK_FILL) && !layer_done && !cfg_err_q;
    assign out_valid_o = (state_q[rd_ptr_q] == BANK_READY);
    assign accept      = in_valid_i && in_ready_o && !start_i;
    assign rel_fire    = release_bank_i && out_valid_o;
    assign wr_done     = bank_done[wr_ptr_q];

    assign out_bank_o   = rd_ptr_q;
    assign out_data_o   = bank_data[rd_ptr_q];
    assign layer_done_o = layer_done;
    assign cfg_err_o    = cfg_err_q;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ifmap_bank #(
            .MAX_LINES (MAX_LINES),
            .MAX_ELEMS (MAX_ELEMS),
            .IN_ELEMS  (IN_ELEMS),
            .DATA_W    (DATA_W)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .clear_i     (start_i || (rel_fire && (rd_ptr_q == BW'(b)))),
            .wr_en_i     (accept && (wr_ptr_q == BW'(b))),
            .cfg_lines_i (cfg_lines_q),
            .cfg_elems_i (cfg_elems_q),
            .in_mask_i   (in_mask_i),
            .in_data_i   (in_data_i),
            .done_o      (bank_done[b]),
            .data_o      (bank_data[b])
        );
    end

    // Only one bank is ever in FILL and it is never the READY bank being
    // released, so the three state updates below never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_FREE;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            cfg_lines_q <= CLW'(MAX_LINES);
            cfg_elems_q <= CEW'(MAX_ELEMS);
            cfg_fills_q <= '0;
            cfg_err_q   <= 1'b0;
        end else if (start_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= BANK_FREE;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            cfg_lines_q <= cfg_lines_i;
            cfg_elems_q <= cfg_elems_i;
            cfg_fills_q <= cfg_fills_i;
            cfg_err_q   <= cfg_bad;
        end else begin
            if ((state_q[wr_ptr_q] == BANK_FREE) && !layer_done) begin
                state_q[wr_ptr_q] <= BANK_FILL;
            end
            if (wr_done) begin
                state_q[wr_ptr_q] <= BANK_READY;
                wr_ptr_q          <= next_ptr(wr_ptr_q);
                if (fill_cnt_q != cfg_fills_q) begin
                    fill_cnt_q <= fill_cnt_q + 8'd1;
                end
            end
            if (rel_fire) begin
                state_q[rd_ptr_q] <= BANK_FREE;
                rd_ptr_q          <= next_ptr(rd_ptr_q);
            end
        end
    end

endmodule
`default_nettype wire
